uart_tx_fifo_mmio: RTL and testbench
====================================

Name: uart_tx_fifo_mmio

Overview:
Memory-mapped UART transmit front end. It accepts byte writes from the CPU data bus into a DEPTH-entry FIFO and drains the FIFO into the UART device's tx_valid/tx_ready/tx_data byte handshake. It exposes status (full, empty, level, sticky overflow) and control (enable, flush) registers. It sits between the core's load/store unit and the UART transmitter device.

Parameters:
DEPTH, 16, FIFO entries; power of two, minimum 2
CNT_W, $clog2(DEPTH)+1, width of level counter (derived, not overridable)

Ports:
clk  in  1  system clock; all state on rising edge
rst  in  1  asynchronous, active-high reset
bus_we  in  1  store strobe, one cycle per access
bus_re  in  1  load strobe, one cycle per access
bus_addr  in  4  byte offset; only [3:2] decoded
bus_wdata  in  32  store data
bus_rdata  out  32  load data, registered
tx_valid  out  1  FIFO head valid toward UART device
tx_ready  in  1  UART device can accept byte this cycle
tx_data  out  8  FIFO head byte

Behaviour:
- Reset (async, rst=1): rd_ptr=0, wr_ptr=0, count=0, enable=1, overflow=0, bus_rdata=0. tx_valid=0 because the FIFO is empty.
- Register map, selected by bus_addr[3:2]:
  - 0 TXDATA: write pushes bus_wdata[7:0]; read returns 0.
  - 1 STATUS: read returns {16'b0, count zero-extended to 8 bits in [15:8], 5'b0, overflow[2], empty[1], full[0]}. Writing 1 to bit2 clears overflow.
  - 2 CTRL: read returns bit0=enable. Write sets enable=bus_wdata[0]; bus_wdata[1]=1 flushes (self-clearing, not stored).
  - 3: reads return 0; writes are ignored.
- full = (count==DEPTH); empty = (count==0).
- Push = we to TXDATA && !full. A write to TXDATA while full drops the byte and sets overflow.
- Full is evaluated on pre-cycle count. A push while full is dropped even if a pop happens in the same cycle.
- tx_valid = !empty && enable (combinational). tx_data = mem[rd_ptr] (combinational from storage).
- Pop = tx_valid && tx_ready. On pop, rd_ptr advances; on push, mem[wr_ptr] is written and wr_ptr advances.
- Pointers are $clog2(DEPTH) bits and wrap naturally modulo DEPTH.
- Simultaneous push and pop (not full, not empty): count unchanged, both pointers advance.
- Push into empty FIFO: tx_valid rises the next cycle. There is no same-cycle bypass.
- enable=0: tx_valid is held low and bytes stay queued. Pushes continue normally.
- Flush: rd_ptr=wr_ptr=0, count=0. It takes priority over push and pop in the same cycle; a concurrent push is discarded without setting overflow. Overflow is not cleared by flush.
- Load latency is 1 cycle: bus_rdata is valid the cycle after bus_re and holds until the next bus_re. STATUS reflects state before any same-cycle update.
- If bus_we and bus_re are both set, both are performed, and the read returns pre-update state.
- Reset mid-transfer: all queued bytes are lost. tx_valid drops asynchronously with rst.
- The FIFO never overwrites an unread entry and never pops when empty.

Decomposition:
- Shared uart package holds the register offsets (UART_TXDATA=0, UART_STATUS=1, UART_CTRL=2) and the STATUS/CTRL bit index constants, for reuse by software headers and the bench.
- One sub-module is natural: sync_fifo (DEPTH, WIDTH=8), a generic FIFO with push/pop/flush and full/empty/count.
- The register decode and overflow/enable logic stay in uart_tx_fifo_mmio.

Test Plan:
- Reset, then read STATUS -> bus_rdata=0x00000002 (empty); tx_valid=0; read CTRL -> 0x1.
- Write TXDATA 0x41, 0x42, 0x43 with tx_ready=1 continuously -> tx_data sequence 0x41, 0x42, 0x43 on consecutive pops; tx_valid first high one cycle after the first write; STATUS ends at 0x00000002.
- With tx_ready=0, write 17 bytes 0x00..0x10 -> STATUS=0x00001005 (count 16, full, overflow); release tx_ready -> 0x00..0x0F drained and 0x10 never appears.
- Fill to 16, then in one cycle write TXDATA 0xAA with tx_ready=1 -> 0xAA dropped, overflow=1, count=15. Write STATUS bit2=1 -> overflow=0.
- Write CTRL=0x0, push 4 bytes -> tx_valid stays 0 with count=4. Write CTRL=0x3 -> flush; STATUS=0x00000002 and no byte is emitted.
- Assert rst asynchronously between clk edges while holding 5 bytes -> tx_valid falls immediately; STATUS reads 0x00000002 after release.
- Wrap check: stream 40 bytes with random tx_ready -> output order matches input, no loss, no duplicate.

Source files
------------

// File: rtl/uart_tx_fifo_mmio_pkg.sv
// Shared UART TX register map: register offsets and STATUS/CTRL bit positions.
// Used by the MMIO front end, software headers and the bench.
// Also holds the helper that packs the STATUS read word.
package uart_tx_fifo_mmio_pkg;

    // Register select, taken from bus_addr[3:2]
    typedef enum logic [1:0] {
        UART_TXDATA = 2'd0,
        UART_STATUS = 2'd1,
        UART_CTRL   = 2'd2,
        UART_RSVD   = 2'd3
    } uart_reg_e;

    // STATUS bit positions
    localparam int STAT_FULL_BIT  = 0;
    localparam int STAT_EMPTY_BIT = 1;
    localparam int STAT_OVF_BIT   = 2;
    localparam int STAT_LVL_LSB   = 8;

    // CTRL bit positions
    localparam int CTRL_EN_BIT    = 0;
    localparam int CTRL_FLUSH_BIT = 1;

    // STATUS word: {16'b0, level[15:8], 5'b0, overflow, empty, full}
    function automatic logic [31:0] status_word(input logic [7:0] lvl,
                                                input logic       ovf,
                                                input logic       emp,
                                                input logic       ful);
        logic [31:0] w;
        w = '0;
        w[STAT_LVL_LSB +: 8] = lvl;
        w[STAT_OVF_BIT]      = ovf;
        w[STAT_EMPTY_BIT]    = emp;
        w[STAT_FULL_BIT]     = ful;
        return w;
    endfunction

endpackage

// File: rtl/uart_tx_fifo_mmio_sync_fifo.sv
// Generic synchronous FIFO with push/pop/flush and full/empty/count status.
// Latency: a pushed entry is visible at head the cycle after the push; no bypass.
// Backpressure: push while full and pop while empty are ignored; flush wins over both.
// Ports: clk, rst (async high); push/push_data, pop, flush in; full, empty, count, head out.
module uart_tx_fifo_mmio_sync_fifo #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 8,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    input  logic             flush,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] count,
    output logic [WIDTH-1:0] head
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic             push_ok;
    logic             pop_ok;

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    // Guards are on pre-cycle count, so a push while full is dropped even
    // if a pop frees a slot in the same cycle.
    assign push_ok = push && !full && !flush;
    assign pop_ok  = pop && !empty && !flush;
    assign head    = mem[rd_ptr];

    // Storage carries no reset; contents are meaningless while count is 0.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            // Pointers are exactly log2(DEPTH) wide so they wrap on their own
            if (push_ok) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push_ok, pop_ok})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/uart_tx_fifo_mmio.sv
// MMIO UART transmit front end: CPU byte stores into a FIFO drained over tx_valid/tx_ready.
// Latency: loads return one cycle after bus_re; a stored byte reaches tx_valid the next cycle.
// Backpressure: tx_ready low holds bytes queued; TXDATA stores while full are dropped and flag overflow.
// Ports: clk, rst (async high); bus_we/bus_re/bus_addr/bus_wdata in, bus_rdata out (registered);
//        tx_valid/tx_data out, tx_ready in.
module uart_tx_fifo_mmio
    import uart_tx_fifo_mmio_pkg::*;
#(
    parameter int DEPTH = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        bus_we,
    input  logic        bus_re,
    input  logic [3:0]  bus_addr,
    input  logic [31:0] bus_wdata,
    output logic [31:0] bus_rdata,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic [7:0]  tx_data
);

    localparam int CNT_W = $clog2(DEPTH) + 1;

    uart_reg_e        reg_sel;
    logic             wr_txdata;
    logic             wr_status;
    logic             wr_ctrl;
    logic             flush;
    logic             pop;
    logic             full;
    logic             empty;
    logic [CNT_W-1:0] level;
    logic             enable;
    logic             overflow;
    logic [31:0]      rd_mux;
    logic             unused_bits;

    assign reg_sel   = uart_reg_e'(bus_addr[3:2]);
    assign wr_txdata = bus_we && (reg_sel == UART_TXDATA);
    assign wr_status = bus_we && (reg_sel == UART_STATUS);
    assign wr_ctrl   = bus_we && (reg_sel == UART_CTRL);
    assign flush     = wr_ctrl && bus_wdata[CTRL_FLUSH_BIT];

    // Byte offset within the word and upper store data are not decoded
    assign unused_bits = ^{bus_addr[1:0], bus_wdata[31:8]};

    // Empty is driven from the asynchronously reset count, so tx_valid
    // drops the moment rst rises.
    assign tx_valid = !empty && enable;
    assign pop      = tx_valid && tx_ready;

    uart_tx_fifo_mmio_sync_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (8)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (wr_txdata),
        .push_data (bus_wdata[7:0]),
        .pop       (pop),
        .flush     (flush),
        .full      (full),
        .empty     (empty),
        .count     (level),
        .head      (tx_data)
    );

    // Enable and sticky overflow. A single bus cycle addresses one register,
    // so the set and clear sources for overflow can never coincide.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            enable   <= 1'b1;
            overflow <= 1'b0;
        end else begin
            if (wr_ctrl) begin
                enable <= bus_wdata[CTRL_EN_BIT];
            end
            if (wr_txdata && full) begin
                overflow <= 1'b1;
            end else if (wr_status && bus_wdata[STAT_OVF_BIT]) begin
                overflow <= 1'b0;
            end
        end
    end

    // Read mux sees pre-update state, so a same-cycle store is not reflected
    always_comb begin
        rd_mux = '0;
        case (reg_sel)
            UART_STATUS: rd_mux = status_word(8'(level), overflow, empty, full);
            UART_CTRL:   rd_mux[CTRL_EN_BIT] = enable;
            default:     rd_mux = '0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus_rdata <= '0;
        end else if (bus_re) begin
            bus_rdata <= rd_mux;
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo_mmio.sv
// Directed bench for uart_tx_fifo_mmio: vector table for single-cycle register
// and handshake behaviour, then hand-written sequences for overflow, flush,
// disable, async reset and pointer wrap.
module tb_uart_tx_fifo_mmio;

    logic        clk;
    logic        rst;
    logic        bus_we;
    logic        bus_re;
    logic [3:0]  bus_addr;
    logic [31:0] bus_wdata;
    logic [31:0] bus_rdata;
    logic        tx_valid;
    logic        tx_ready;
    logic [7:0]  tx_data;

    int total = 0;
    int bad   = 0;

    logic [7:0] got[$];

    uart_tx_fifo_mmio #(.DEPTH(16)) dut (
        .clk       (clk),
        .rst       (rst),
        .bus_we    (bus_we),
        .bus_re    (bus_re),
        .bus_addr  (bus_addr),
        .bus_wdata (bus_wdata),
        .bus_rdata (bus_rdata),
        .tx_valid  (tx_valid),
        .tx_ready  (tx_ready),
        .tx_data   (tx_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs change only at posedge+1, so a handshake seen at negedge is
    // exactly the pop taken at the following posedge.
    always @(negedge clk) begin
        if (!rst && tx_valid && tx_ready) begin
            got.push_back(tx_data);
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic        we;
        logic        re;
        logic [3:0]  addr;
        logic [31:0] wdata;
        logic        rdy;
        logic [31:0] exp_rdata;
        logic        exp_vld;
        logic [7:0]  exp_dat;
    } vec_t;

    vec_t vt[17];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic bus_write(input logic [3:0] a, input logic [31:0] d);
        bus_we    = 1'b1;
        bus_addr  = a;
        bus_wdata = d;
        step();
        bus_we    = 1'b0;
    endtask

    task automatic bus_read(input logic [3:0] a, output logic [31:0] d);
        bus_re   = 1'b1;
        bus_addr = a;
        step();
        bus_re   = 1'b0;
        d        = bus_rdata;
    endtask

    initial begin
        logic [31:0] rd;
        int n;
        int sent;
        int cyc;

        //           we    re    addr   wdata         rdy   exp_rdata     vld   dat
        vt[0]  = '{1'b0, 1'b1, 4'h4, 32'h0,        1'b1, 32'h00000002, 1'b0, 8'h00};
        vt[1]  = '{1'b0, 1'b1, 4'h8, 32'h0,        1'b1, 32'h00000001, 1'b0, 8'h00};
        vt[2]  = '{1'b1, 1'b0, 4'h0, 32'h41,       1'b1, 32'h00000001, 1'b1, 8'h41};
        vt[3]  = '{1'b1, 1'b0, 4'h0, 32'h42,       1'b1, 32'h00000001, 1'b1, 8'h42};
        vt[4]  = '{1'b1, 1'b0, 4'h0, 32'h43,       1'b1, 32'h00000001, 1'b1, 8'h43};
        vt[5]  = '{1'b0, 1'b0, 4'h0, 32'h0,        1'b1, 32'h00000001, 1'b0, 8'h00};
        vt[6]  = '{1'b0, 1'b1, 4'h4, 32'h0,        1'b1, 32'h00000002, 1'b0, 8'h00};
        vt[7]  = '{1'b0, 1'b1, 4'hC, 32'h0,        1'b1, 32'h00000000, 1'b0, 8'h00};
        vt[8]  = '{1'b0, 1'b1, 4'h0, 32'h0,        1'b1, 32'h00000000, 1'b0, 8'h00};
        vt[9]  = '{1'b1, 1'b0, 4'hC, 32'hFFFFFFFF, 1'b0, 32'h00000000, 1'b0, 8'h00};
        vt[10] = '{1'b0, 1'b1, 4'h8, 32'h0,        1'b0, 32'h00000001, 1'b0, 8'h00};
        vt[11] = '{1'b1, 1'b0, 4'h0, 32'h5A,       1'b0, 32'h00000001, 1'b1, 8'h5A};
        vt[12] = '{1'b0, 1'b1, 4'h4, 32'h0,        1'b0, 32'h00000100, 1'b1, 8'h5A};
        vt[13] = '{1'b1, 1'b1, 4'h0, 32'h77,       1'b0, 32'h00000000, 1'b1, 8'h5A};
        vt[14] = '{1'b0, 1'b1, 4'h4, 32'h0,        1'b1, 32'h00000200, 1'b1, 8'h77};
        vt[15] = '{1'b0, 1'b0, 4'h0, 32'h0,        1'b1, 32'h00000200, 1'b0, 8'h00};
        vt[16] = '{1'b0, 1'b1, 4'h4, 32'h0,        1'b1, 32'h00000002, 1'b0, 8'h00};

        rst       = 1'b1;
        bus_we    = 1'b0;
        bus_re    = 1'b0;
        bus_addr  = 4'h0;
        bus_wdata = 32'h0;
        tx_ready  = 1'b0;
        step();
        step();
        chk("reset_tx_valid", {31'b0, tx_valid}, 32'h0);
        chk("reset_rdata", bus_rdata, 32'h0);
        rst = 1'b0;

        // ---------------- table-driven vectors ----------------
        for (int i = 0; i < 17; i++) begin
            bus_we    = vt[i].we;
            bus_re    = vt[i].re;
            bus_addr  = vt[i].addr;
            bus_wdata = vt[i].wdata;
            tx_ready  = vt[i].rdy;
            step();
            chk($sformatf("vec%0d_rdata", i), bus_rdata, vt[i].exp_rdata);
            chk($sformatf("vec%0d_tx_valid", i), {31'b0, tx_valid}, {31'b0, vt[i].exp_vld});
            if (vt[i].exp_vld) begin
                chk($sformatf("vec%0d_tx_data", i), {24'b0, tx_data}, {24'b0, vt[i].exp_dat});
            end
        end
        bus_we = 1'b0;
        bus_re = 1'b0;

        // ---------------- overflow on 17th byte, then drain ----------------
        tx_ready = 1'b0;
        got.delete();
        for (int i = 0; i <= 16; i++) bus_write(4'h0, 32'(i));
        bus_read(4'h4, rd);
        chk("ovf_status_full", rd, 32'h00001005);
        tx_ready = 1'b1;
        n = 0;
        while (tx_valid && n < 40) begin
            step();
            n++;
        end
        chk("ovf_drain_done", {31'b0, tx_valid}, 32'h0);
        chk("ovf_drain_count", 32'(got.size()), 32'd16);
        for (int i = 0; i < 16; i++) begin
            chk($sformatf("ovf_byte%0d", i),
                (i < got.size()) ? {24'b0, got[i]} : 32'hDEAD_BEEF, 32'(i));
        end
        tx_ready = 1'b0;
        bus_write(4'h4, 32'h4);
        bus_read(4'h4, rd);
        chk("ovf_cleared", rd, 32'h00000002);

        // ---------------- push while full with same-cycle pop ----------------
        got.delete();
        for (int i = 0; i < 16; i++) bus_write(4'h0, 32'h20 + 32'(i));
        tx_ready = 1'b1;
        bus_write(4'h0, 32'hAA);
        tx_ready = 1'b0;
        bus_read(4'h4, rd);
        chk("fullpop_status", rd, 32'h00000F04);
        chk("fullpop_popcnt", 32'(got.size()), 32'd1);
        chk("fullpop_popbyte", (got.size() > 0) ? {24'b0, got[0]} : 32'hDEAD_BEEF, 32'h20);
        bus_write(4'h4, 32'h4);
        bus_read(4'h4, rd);
        chk("fullpop_ovf_clr", rd, 32'h00000F00);
        bus_write(4'h8, 32'h3);
        bus_read(4'h4, rd);
        chk("fullpop_flushed", rd, 32'h00000002);

        // ---------------- disabled output, then flush ----------------
        got.delete();
        bus_write(4'h8, 32'h0);
        tx_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            bus_write(4'h0, 32'h60 + 32'(i));
            chk($sformatf("dis_tx_valid%0d", i), {31'b0, tx_valid}, 32'h0);
        end
        bus_read(4'h4, rd);
        chk("dis_status", rd, 32'h00000400);
        bus_read(4'h8, rd);
        chk("dis_ctrl", rd, 32'h00000000);
        bus_write(4'h8, 32'h3);
        chk("flush_tx_valid", {31'b0, tx_valid}, 32'h0);
        bus_read(4'h4, rd);
        chk("flush_status", rd, 32'h00000002);
        repeat (3) step();
        chk("flush_no_emit", 32'(got.size()), 32'd0);
        bus_read(4'h8, rd);
        chk("flush_ctrl", rd, 32'h00000001);

        // ---------------- async reset with bytes queued ----------------
        tx_ready = 1'b0;
        for (int i = 0; i < 5; i++) bus_write(4'h0, 32'h90 + 32'(i));
        chk("arst_pre_valid", {31'b0, tx_valid}, 32'h1);
        #2 rst = 1'b1;
        #1;
        chk("arst_valid_drop", {31'b0, tx_valid}, 32'h0);
        chk("arst_rdata", bus_rdata, 32'h0);
        step();
        rst = 1'b0;
        bus_read(4'h4, rd);
        chk("arst_status", rd, 32'h00000002);
        bus_read(4'h8, rd);
        chk("arst_ctrl", rd, 32'h00000001);

        // ---------------- wrap: 40 bytes with random tx_ready ----------------
        got.delete();
        sent = 0;
        cyc  = 0;
        while (sent < 40 && cyc < 2000) begin
            tx_ready = 1'($urandom_range(0, 1));
            if (sent - int'(got.size()) < 16) begin
                bus_write(4'h0, 32'h80 + 32'(sent));
                sent++;
            end else begin
                step();
            end
            cyc++;
        end
        tx_ready = 1'b1;
        n = 0;
        while (tx_valid && n < 100) begin
            step();
            n++;
        end
        chk("wrap_count", 32'(got.size()), 32'd40);
        for (int i = 0; i < 40; i++) begin
            chk($sformatf("wrap_byte%0d", i),
                (i < got.size()) ? {24'b0, got[i]} : 32'hDEAD_BEEF, 32'h80 + 32'(i));
        end
        bus_read(4'h4, rd);
        chk("wrap_status", rd, 32'h00000002);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
